// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants and the write-back entry layout used by the
// load-return path into the register file.
package cpu_pkg;

  localparam int unsigned REG_W    = 4;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned NUM_REGS = 16;

  typedef struct packed {
    logic [REG_W-1:0]  dst;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO for load returns. Pointers carry one extra wrap bit so
// that full and empty can be told apart.
module wb_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign dout = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: ALU results take priority, buffered load
// returns fill idle cycles, and a busy/stale scoreboard guards RAW/WAW order.
module wb_arbiter #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned REG_W  = cpu_pkg::REG_W,
  parameter int unsigned DATA_W = cpu_pkg::DATA_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alu_valid,
  input  logic [REG_W-1:0]             alu_dst,
  input  logic [DATA_W-1:0]            alu_data,
  input  logic                         ld_issue,
  input  logic [REG_W-1:0]             ld_issue_dst,
  input  logic                         ld_valid,
  input  logic [REG_W-1:0]             ld_dst,
  input  logic [DATA_W-1:0]            ld_data,
  output logic                         ld_ready,
  output logic [cpu_pkg::NUM_REGS-1:0] busy_mask,
  output logic [REG_W-1:0]             DstReg,
  output logic                         WriteReg,
  output logic [DATA_W-1:0]            DstData
);

  import cpu_pkg::*;

  localparam int unsigned EW = REG_W + DATA_W;

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [NUM_REGS-1:0] stale_q, stale_d;
  logic                wr_d;
  logic [REG_W-1:0]    dst_d;
  logic [DATA_W-1:0]   data_d;

  logic                fifo_full, fifo_empty;
  logic                push, pop;
  logic [EW-1:0]       head;
  logic [REG_W-1:0]    hd_dst;
  logic [DATA_W-1:0]   hd_data;

  assign ld_ready = !fifo_full;
  assign push     = ld_valid && ld_ready;
  assign pop      = !alu_valid && !fifo_empty;
  assign hd_dst   = head[EW-1:DATA_W];
  assign hd_data  = head[DATA_W-1:0];

  wb_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ({ld_dst, ld_data}),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    busy_d  = busy_q;
    stale_d = stale_q;
    wr_d    = 1'b0;
    dst_d   = DstReg;
    data_d  = DstData;

    if (alu_valid) begin
      wr_d = (alu_dst != '0);
      if (wr_d) begin
        dst_d  = alu_dst;
        data_d = alu_data;
      end
      // The pending load for this register is now older than this result.
      if (busy_q[alu_dst]) stale_d[alu_dst] = 1'b1;
    end else if (pop) begin
      wr_d = (hd_dst != '0) && !stale_q[hd_dst];
      if (wr_d) begin
        dst_d  = hd_dst;
        data_d = hd_data;
      end
      busy_d[hd_dst]  = 1'b0;
      stale_d[hd_dst] = 1'b0;
    end

    // Applied last so a new issue wins over a same-cycle pop clear.
    if (ld_issue && (ld_issue_dst != '0)) busy_d[ld_issue_dst] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q   <= '0;
      stale_q  <= '0;
      WriteReg <= 1'b0;
      DstReg   <= '0;
      DstData  <= '0;
    end else begin
      busy_q   <= busy_d;
      stale_q  <= stale_d;
      WriteReg <= wr_d;
      DstReg   <= dst_d;
      DstData  <= data_d;
    end
  end

  assign busy_mask = busy_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed vector table, mid-stream reset, and a
// randomized run against a queue-based reference model.
module tb_wb_arbiter;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [3:0]  alu_dst;
  logic [15:0] alu_data;
  logic        ld_issue;
  logic [3:0]  ld_issue_dst;
  logic        ld_valid;
  logic [3:0]  ld_dst;
  logic [15:0] ld_data;
  logic        ld_ready;
  logic [15:0] busy_mask;
  logic [3:0]  DstReg;
  logic        WriteReg;
  logic [15:0] DstData;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  wb_arbiter #(
    .DEPTH  (DEPTH),
    .REG_W  (4),
    .DATA_W (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .alu_valid    (alu_valid),
    .alu_dst      (alu_dst),
    .alu_data     (alu_data),
    .ld_issue     (ld_issue),
    .ld_issue_dst (ld_issue_dst),
    .ld_valid     (ld_valid),
    .ld_dst       (ld_dst),
    .ld_data      (ld_data),
    .ld_ready     (ld_ready),
    .busy_mask    (busy_mask),
    .DstReg       (DstReg),
    .WriteReg     (WriteReg),
    .DstData      (DstData)
  );

  typedef struct {
    logic        av;
    logic [3:0]  ad;
    logic [15:0] adata;
    logic        li;
    logic [3:0]  lid;
    logic        lv;
    logic [3:0]  ldst;
    logic [15:0] ldata;
    logic        ewr;
    logic [3:0]  edst;
    logic [15:0] edata;
    logic [15:0] ebusy;
    logic        erdy;
  } vec_t;

  typedef struct {
    logic [3:0]  d;
    logic [15:0] v;
  } ent_t;

  vec_t tbl[$];

  // Reference model state: FIFO contents as a queue, busy/stale as bit sets.
  ent_t        mq[$];
  logic [15:0] mbusy;
  logic [15:0] mstale;
  logic        mwr;
  logic [3:0]  mdst;
  logic [15:0] mdata;

  function automatic vec_t mk(input logic av, input logic [3:0] ad, input logic [15:0] adata,
                              input logic li, input logic [3:0] lid,
                              input logic lv, input logic [3:0] ldst, input logic [15:0] ldata,
                              input logic ewr, input logic [3:0] edst, input logic [15:0] edata,
                              input logic [15:0] ebusy, input logic erdy);
    vec_t v;
    v.av = av; v.ad = ad; v.adata = adata; v.li = li; v.lid = lid;
    v.lv = lv; v.ldst = ldst; v.ldata = ldata;
    v.ewr = ewr; v.edst = edst; v.edata = edata; v.ebusy = ebusy; v.erdy = erdy;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic check_out(input string tag, input logic ewr, input logic [3:0] edst,
                           input logic [15:0] edata, input logic [15:0] ebusy, input logic erdy);
    check({tag, " WriteReg"}, 32'(WriteReg), 32'(ewr));
    if (ewr) begin
      check({tag, " DstReg"}, 32'(DstReg), 32'(edst));
      check({tag, " DstData"}, 32'(DstData), 32'(edata));
    end
    check({tag, " busy_mask"}, 32'(busy_mask), 32'(ebusy));
    check({tag, " ld_ready"}, 32'(ld_ready), 32'(erdy));
  endtask

  task automatic set_in(input vec_t v);
    alu_valid = v.av; alu_dst = v.ad; alu_data = v.adata;
    ld_issue = v.li; ld_issue_dst = v.lid;
    ld_valid = v.lv; ld_dst = v.ldst; ld_data = v.ldata;
  endtask

  task automatic idle_in();
    alu_valid = 1'b0; alu_dst = '0; alu_data = '0;
    ld_issue = 1'b0; ld_issue_dst = '0;
    ld_valid = 1'b0; ld_dst = '0; ld_data = '0;
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
    mbusy = '0; mstale = '0; mwr = 1'b0; mdst = '0; mdata = '0;
  endtask

  // One clock of architectural behaviour, stated directly from the rules.
  task automatic model_step();
    ent_t e;
    bit   room;
    room = (mq.size() < DEPTH);
    mwr  = 1'b0;
    if (alu_valid) begin
      if (alu_dst != 0) begin mwr = 1'b1; mdst = alu_dst; mdata = alu_data; end
      if (mbusy[alu_dst]) mstale[alu_dst] = 1'b1;
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      if (e.d != 0 && !mstale[e.d]) begin mwr = 1'b1; mdst = e.d; mdata = e.v; end
      mbusy[e.d] = 1'b0;
      mstale[e.d] = 1'b0;
    end
    if (ld_valid && room) begin
      e.d = ld_dst; e.v = ld_data;
      mq.push_back(e);
    end
    if (ld_issue && ld_issue_dst != 0) mbusy[ld_issue_dst] = 1'b1;
  endtask

  initial begin
    logic [3:0] pending[$];
    ent_t       dummy;

    rst = 1'b1;
    idle_in();
    #2;
    check("async reset WriteReg", 32'(WriteReg), 32'd0);
    check("async reset busy_mask", 32'(busy_mask), 32'd0);
    check("async reset ld_ready", 32'(ld_ready), 32'd1);
    do_reset();
    check("reset DstReg", 32'(DstReg), 32'd0);
    check("reset DstData", 32'(DstData), 32'd0);

    //            av ad  adata    li lid lv ldst ldata   | wr dst data     busy      rdy
    tbl.push_back(mk(1, 3, 16'hBEEF, 0, 0, 0, 0, 16'h0000, 1, 3, 16'hBEEF, 16'h0000, 1));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1));
    tbl.push_back(mk(1, 0, 16'h1111, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 5, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0020, 1));
    tbl.push_back(mk(1, 1, 16'h0001, 0, 0, 1, 5, 16'h1234, 1, 1, 16'h0001, 16'h0020, 1));
    tbl.push_back(mk(1, 2, 16'h0002, 0, 0, 0, 0, 16'h0000, 1, 2, 16'h0002, 16'h0020, 1));
    tbl.push_back(mk(1, 3, 16'h0003, 0, 0, 0, 0, 16'h0000, 1, 3, 16'h0003, 16'h0020, 1));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 1, 5, 16'h1234, 16'h0000, 1));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 7, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0080, 1));
    tbl.push_back(mk(1, 7, 16'h00AA, 0, 0, 0, 0, 16'h0000, 1, 7, 16'h00AA, 16'h0080, 1));
    tbl.push_back(mk(1, 4, 16'h0004, 0, 0, 1, 7, 16'h5555, 1, 4, 16'h0004, 16'h0080, 1));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 8, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0100, 1));
    tbl.push_back(mk(1, 1, 16'h0010, 1, 9, 0, 0, 16'h0000, 1, 1, 16'h0010, 16'h0300, 1));
    tbl.push_back(mk(1, 2, 16'h0020, 0, 0, 1, 8, 16'h8888, 1, 2, 16'h0020, 16'h0300, 1));
    tbl.push_back(mk(1, 3, 16'h0030, 0, 0, 1, 9, 16'h9999, 1, 3, 16'h0030, 16'h0300, 0));
    tbl.push_back(mk(1, 4, 16'h0040, 0, 0, 1,10, 16'hAAAA, 1, 4, 16'h0040, 16'h0300, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 1, 8, 16'h8888, 16'h0200, 1));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 9, 0, 0, 16'h0000, 1, 9, 16'h9999, 16'h0200, 1));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0200, 1));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 1, 9, 16'h1357, 0, 0, 16'h0000, 16'h0200, 1));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 1, 9, 16'h1357, 16'h0000, 1));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 1, 0, 16'hFFFF, 0, 0, 16'h0000, 16'h0000, 1));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1));

    foreach (tbl[i]) begin
      set_in(tbl[i]);
      @(posedge clk);
      #1;
      check_out($sformatf("vec%0d", i), tbl[i].ewr, tbl[i].edst, tbl[i].edata,
                tbl[i].ebusy, tbl[i].erdy);
    end

    // Reset asserted mid-cycle while the FIFO holds two entries and ALU writes.
    idle_in();
    ld_issue = 1'b1; ld_issue_dst = 4'd11;
    @(posedge clk); #1;
    ld_issue_dst = 4'd12; alu_valid = 1'b1; alu_dst = 4'd1; alu_data = 16'h0101;
    @(posedge clk); #1;
    ld_issue = 1'b0; alu_dst = 4'd2; ld_valid = 1'b1; ld_dst = 4'd11; ld_data = 16'h1111;
    @(posedge clk); #1;
    alu_dst = 4'd3; ld_dst = 4'd12; ld_data = 16'h2222;
    @(posedge clk); #1;
    check_out("pre-reset", 1'b1, 4'd3, 16'h0101, 16'h1800, 1'b0);
    ld_valid = 1'b0; alu_dst = 4'd4;
    #3;
    rst = 1'b1;
    #1;
    check("midreset WriteReg", 32'(WriteReg), 32'd0);
    check("midreset busy_mask", 32'(busy_mask), 32'd0);
    check("midreset ld_ready", 32'(ld_ready), 32'd1);
    idle_in();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check_out($sformatf("postreset%0d", k), 1'b0, 4'd0, 16'h0, 16'h0000, 1'b1);
    end

    // Randomized traffic against the reference model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [3:0] d;
      int         idx;
      idle_in();
      alu_valid = ($urandom_range(0, 99) < 45);
      alu_dst   = 4'($urandom_range(0, 15));
      alu_data  = 16'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        d = 4'($urandom_range(0, 15));
        if (!mbusy[d]) begin
          ld_issue = 1'b1; ld_issue_dst = d;
        end
      end
      if (pending.size() > 0 && mq.size() < DEPTH && $urandom_range(0, 1) == 1) begin
        idx = $urandom_range(0, pending.size() - 1);
        ld_valid = 1'b1; ld_dst = pending[idx]; ld_data = 16'($urandom);
        pending.delete(idx);
      end else if (mq.size() == DEPTH && $urandom_range(0, 9) == 0) begin
        ld_valid = 1'b1; ld_dst = 4'($urandom_range(0, 15)); ld_data = 16'($urandom);
      end
      if (ld_issue) pending.push_back(ld_issue_dst);
      model_step();
      @(posedge clk);
      #1;
      check_out($sformatf("rand%0d", c), mwr, mdst, mdata, mbusy, mq.size() < DEPTH);
    end
    dummy.d = '0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
